time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_if.sv | 41 ++++
 rtl/time_set_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================
// time_set_ctrl_if : button inputs and time/display outputs
// Rev 1.0
// ============================================================
interface time_set_ctrl_if;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] hr_tens;
   logic [3:0] hr_ones;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [5:0] sec;
   logic [1:0] mode;
   logic [3:0] blank_mask;

   modport master (
      output btn_mode,
      output btn_inc,
      input  hr_tens,
      input  hr_ones,
      input  min_tens,
      input  min_ones,
      input  sec,
      input  mode,
      input  blank_mask
   );

   modport slave (
      input  btn_mode,
      input  btn_inc,
      output hr_tens,
      output hr_ones,
      output min_tens,
      output min_ones,
      output sec,
      output mode,
      output blank_mask
   );
endinterface
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================
// time_set_ctrl : HH:MM:SS clock with button-driven set mode
// Rev 1.0
// ============================================================
module time_set_ctrl #(
   parameter int TICK_DIV   = 100000000,
   parameter int REPEAT_DIV = 25000000,
   parameter int BLINK_DIV  = 50000000
) (
   input  logic           CLK100MHZ,
   input  logic           CPU_RESETN,
   time_set_ctrl_if.slave bus
);
   localparam int TICK_W  = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
   localparam int REP_W   = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic               mode_prev;
   logic               inc_prev;
   logic               mode_edge;
   logic               inc_edge;
   logic               set_state;
   logic               tick;
   logic               rpt_fire;
   logic               inc_pulse;

   logic [TICK_W-1:0]  presc;
   logic [REP_W-1:0]   rpt_cnt;
   logic               rpt_active;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   logic [3:0]         hr10;
   logic [3:0]         hr1;
   logic [3:0]         mn10;
   logic [3:0]         mn1;
   logic [5:0]         sec_cnt;
   logic [3:0]         hr10_nxt;
   logic [3:0]         hr1_nxt;
   logic [3:0]         mn10_nxt;
   logic [3:0]         mn1_nxt;
   logic [5:0]         sec_nxt;
   logic               min_inc;
   logic               min_wrap;
   logic               hr_inc;
   logic [3:0]         blank;

   assign mode_edge = bus.btn_mode & ~mode_prev;
   assign inc_edge  = bus.btn_inc  & ~inc_prev;
   assign set_state = (state != RUN);
   assign tick      = (state == RUN) && (presc == TICK_W'(TICK_DIV - 1));
   assign rpt_fire  = rpt_active & bus.btn_inc & (rpt_cnt == REP_W'(REPEAT_DIV - 1));
   // A coincident mode edge always swallows the increment.
   assign inc_pulse = set_state & ~mode_edge & (inc_edge | rpt_fire);

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         mode_prev <= 1'b0;
         inc_prev  <= 1'b0;
      end else begin
         mode_prev <= bus.btn_mode;
         inc_prev  <= bus.btn_inc;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (mode_edge) begin
         case (state)
            RUN:     state_nxt = SET_HR;
            SET_HR:  state_nxt = SET_MIN;
            default: state_nxt = RUN;
         endcase
      end
   end

   // Leaving SET_MIN restarts the second so the first tick is a full period away.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         presc <= '0;
      end else if ((state == SET_MIN) && mode_edge) begin
         presc <= '0;
      end else if (state == RUN) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         rpt_active <= 1'b0;
         rpt_cnt    <= '0;
      end else if (mode_edge || !bus.btn_inc || !set_state) begin
         rpt_active <= 1'b0;
         rpt_cnt    <= '0;
      end else if (inc_edge) begin
         rpt_active <= 1'b1;
         rpt_cnt    <= '0;
      end else if (rpt_active) begin
         rpt_cnt <= rpt_fire ? '0 : rpt_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (mode_edge || inc_pulse || !set_state) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      hr10_nxt = hr10;
      hr1_nxt  = hr1;
      mn10_nxt = mn10;
      mn1_nxt  = mn1;
      sec_nxt  = sec_cnt;
      min_inc  = 1'b0;
      min_wrap = 1'b0;
      hr_inc   = 1'b0;

      case (state)
         RUN: begin
            if (tick) begin
               if (sec_cnt >= 6'd59) begin
                  sec_nxt = 6'd0;
                  min_inc = 1'b1;
               end else begin
                  sec_nxt = sec_cnt + 6'd1;
               end
            end
         end
         SET_HR: begin
            hr_inc = inc_pulse;
         end
         SET_MIN: begin
            min_inc = inc_pulse;
            if (mode_edge) begin
               sec_nxt = 6'd0;
            end
         end
         default: ;
      endcase

      if (min_inc) begin
         if (mn1 >= 4'd9) begin
            mn1_nxt = 4'd0;
            if (mn10 >= 4'd5) begin
               mn10_nxt = 4'd0;
               min_wrap = 1'b1;
            end else begin
               mn10_nxt = mn10 + 4'd1;
            end
         end else begin
            mn1_nxt = mn1 + 4'd1;
         end
      end

      // Minute roll-over only carries into hours while the clock is running.
      if (hr_inc || (min_wrap && (state == RUN))) begin
         if ((hr10 >= 4'd2) && (hr1 >= 4'd3)) begin
            hr10_nxt = 4'd0;
            hr1_nxt  = 4'd0;
         end else if (hr1 >= 4'd9) begin
            hr1_nxt  = 4'd0;
            hr10_nxt = hr10 + 4'd1;
         end else begin
            hr1_nxt = hr1 + 4'd1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         hr10    <= 4'd0;
         hr1     <= 4'd0;
         mn10    <= 4'd0;
         mn1     <= 4'd0;
         sec_cnt <= 6'd0;
      end else begin
         hr10    <= hr10_nxt;
         hr1     <= hr1_nxt;
         mn10    <= mn10_nxt;
         mn1     <= mn1_nxt;
         sec_cnt <= sec_nxt;
      end
   end

   always_comb begin
      blank = 4'b0000;
      if (blink_phase) begin
         case (state)
            SET_HR:  blank = 4'b1100;
            SET_MIN: blank = 4'b0011;
            default: blank = 4'b0000;
         endcase
      end
   end

   assign bus.hr_tens    = hr10;
   assign bus.hr_ones    = hr1;
   assign bus.min_tens   = mn10;
   assign bus.min_ones   = mn1;
   assign bus.sec        = sec_cnt;
   assign bus.mode       = state;
   assign bus.blank_mask = blank;
endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================
// tb_time_set_ctrl : vector table, directed sequences and random run vs model
// Rev 1.0
// ============================================================
module tb_time_set_ctrl;
   localparam int TD = 4;
   localparam int RD = 8;
   localparam int BD = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   time_set_ctrl_if bus();

   time_set_ctrl #(
      .TICK_DIV   (TD),
      .REPEAT_DIV (RD),
      .BLINK_DIV  (BD)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .bus        (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: time kept as seconds-of-day.
   int m_tsec, m_mode, m_presc, m_k, m_age;
   bit m_armed, m_pm, m_pi;

   function automatic void model_reset();
      m_tsec = 0; m_mode = 0; m_presc = 0; m_k = 0; m_age = 0;
      m_armed = 0; m_pm = 0; m_pi = 0;
   endfunction

   function automatic void model_step(input bit bm, input bit bi);
      bit me, ie, inc;
      int h, m, s;
      me  = bm && !m_pm;
      ie  = bi && !m_pi;
      inc = 0;
      if (m_mode != 0 && !me && bi) begin
         if (ie) begin
            m_armed = 1; m_k = 0; inc = 1;
         end else if (m_armed) begin
            m_k++;
            if (m_k % RD == 0) inc = 1;
         end
      end else begin
         m_armed = 0;
      end
      h = m_tsec / 3600; m = (m_tsec / 60) % 60; s = m_tsec % 60;
      if (m_mode == 0) begin
         if (m_presc == TD - 1) begin
            m_presc = 0;
            m_tsec  = (m_tsec + 1) % 86400;
         end else begin
            m_presc++;
         end
      end else if (m_mode == 1) begin
         if (inc) m_tsec = ((h + 1) % 24) * 3600 + m * 60 + s;
      end else begin
         if (inc) m_tsec = h * 3600 + ((m + 1) % 60) * 60 + s;
         if (me) begin
            m_tsec  = m_tsec - (m_tsec % 60);
            m_presc = 0;
         end
      end
      if (me || inc || m_mode == 0) m_age = 0;
      else m_age++;
      if (me) m_mode = (m_mode + 1) % 3;
      m_pm = bm; m_pi = bi;
   endfunction

   task automatic compare(input string name, input logic [27:0] exp);
      logic [27:0] act;
      act = {bus.hr_tens, bus.hr_ones, bus.min_tens, bus.min_ones,
             bus.sec, bus.mode, bus.blank_mask};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got hh%h mm%h sec%0d mode%0d blank%b, expected hh%h mm%h sec%0d mode%0d blank%b",
                    name, act[27:20], act[19:12], act[11:6], act[5:4], act[3:0],
                    exp[27:20], exp[19:12], exp[11:6], exp[5:4], exp[3:0]);
   endtask

   task automatic check_exp(input string name, input int hr, input int mn, input int sc,
                            input int md, input logic [3:0] bl);
      compare(name, {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10), 6'(sc), 2'(md), bl});
   endtask

   task automatic check_model(input string name);
      logic [3:0] bl;
      bl = 4'b0000;
      if ((m_age / BD) % 2 == 1) begin
         if (m_mode == 1) bl = 4'b1100;
         else if (m_mode == 2) bl = 4'b0011;
      end
      check_exp(name, m_tsec / 3600, (m_tsec / 60) % 60, m_tsec % 60, m_mode, bl);
   endtask

   // Called at a falling edge; applies inputs for one cycle and checks the result.
   task automatic step(input bit bm, input bit bi);
      bus.btn_mode = bm;
      bus.btn_inc  = bi;
      model_step(bm, bi);
      @(negedge clk);
      check_model("model");
   endtask

   task automatic press_mode();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic press_inc();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   // From RUN: enter set mode, dial in h:m, optionally return to RUN (no trailing idle).
   task automatic set_time(input int h, input int m, input bit leave);
      int nh, nm;
      press_mode();
      nh = (h - m_tsec / 3600 + 24) % 24;
      for (int i = 0; i < nh; i++) press_inc();
      press_mode();
      nm = (m - (m_tsec / 60) % 60 + 60) % 60;
      for (int i = 0; i < nm; i++) press_inc();
      if (leave) step(1'b1, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      model_reset();
      #1;
      check_exp("reset_assert", 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit         bm;
      bit         bi;
      int         md;
      int         hr;
      int         mn;
      int         sc;
      logic [3:0] bl;
   } vec_t;

   vec_t tbl [29];

   initial begin
      bit saw_on, saw_off, bi_r, bm_r;

      tbl = '{
         '{1'b1, 1'b0, 1, 0, 0, 0, 4'b0000},
         '{1'b0, 1'b1, 1, 1, 0, 0, 4'b0000},
         '{1'b0, 1'b0, 1, 1, 0, 0, 4'b0000},
         '{1'b0, 1'b1, 1, 2, 0, 0, 4'b0000},
         '{1'b0, 1'b0, 1, 2, 0, 0, 4'b0000},
         '{1'b0, 1'b0, 1, 2, 0, 0, 4'b0000},
         '{1'b0, 1'b0, 1, 2, 0, 0, 4'b1100},
         '{1'b1, 1'b1, 2, 2, 0, 0, 4'b0000},
         '{1'b0, 1'b0, 2, 2, 0, 0, 4'b0000},
         '{1'b0, 1'b1, 2, 2, 1, 0, 4'b0000},
         '{1'b0, 1'b0, 2, 2, 1, 0, 4'b0000},
         '{1'b0, 1'b0, 2, 2, 1, 0, 4'b0000},
         '{1'b0, 1'b0, 2, 2, 1, 0, 4'b0011},
         '{1'b1, 1'b0, 0, 2, 1, 0, 4'b0000},
         '{1'b0, 1'b0, 0, 2, 1, 0, 4'b0000},
         '{1'b0, 1'b0, 0, 2, 1, 0, 4'b0000},
         '{1'b0, 1'b0, 0, 2, 1, 0, 4'b0000},
         '{1'b0, 1'b0, 0, 2, 1, 1, 4'b0000},
         '{1'b1, 1'b0, 1, 2, 1, 1, 4'b0000},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b0000},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b0000},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b0000},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b1100},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b1100},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b1100},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b0000},
         '{1'b0, 1'b1, 1, 3, 1, 1, 4'b0000},
         '{1'b0, 1'b1, 1, 4, 1, 1, 4'b0000},
         '{1'b0, 1'b0, 1, 4, 1, 1, 4'b0000}
      };

      rst_n = 1'b0;
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      model_reset();
      #1;
      check_exp("reset_hold", 0, 0, 0, 0, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table from reset
      for (int i = 0; i < 29; i++) begin
         step(tbl[i].bm, tbl[i].bi);
         check_exp($sformatf("vec%0d", i), tbl[i].hr, tbl[i].mn, tbl[i].sc, tbl[i].md, tbl[i].bl);
      end

      // Idle count from reset: 240 cycles is exactly one minute
      do_reset();
      for (int i = 0; i < 240; i++) step(1'b0, 1'b0);
      check_exp("idle_240", 0, 1, 0, 0, 4'b0000);

      // 25 hour increments with blink observed between presses
      press_mode();
      saw_on = 0; saw_off = 0;
      for (int i = 0; i < 25; i++) begin
         step(1'b0, 1'b1);
         for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0);
            if (bus.blank_mask == 4'b1100) saw_on = 1;
            if (bus.blank_mask == 4'b0000) saw_off = 1;
         end
      end
      check_exp("hr_25_incs", 1, 1, 0, 1, 4'b1100);
      n_total++;
      if ({saw_on, saw_off} == 2'b11) n_pass++;
      else $display("FAIL blink_toggle: saw_on=%0d saw_off=%0d, expected 1 1", saw_on, saw_off);

      // Auto-repeat across the minute wrap, no hour carry
      press_mode();
      for (int i = 0; i < 57; i++) press_inc();
      check_exp("min_58", 1, 58, 0, 2, 4'b0000);
      for (int i = 0; i < 17; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_exp("hold_17", 1, 1, 0, 2, 4'b0000);
      step(1'b1, 1'b0);
      check_exp("exit_set", 1, 1, 0, 0, 4'b0000);
      step(1'b0, 1'b0);

      // Day roll-over from 23:59:59
      set_time(23, 59, 1'b1);
      for (int i = 0; i < 236; i++) step(1'b0, 1'b0);
      check_exp("at_235959", 23, 59, 59, 0, 4'b0000);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      check_exp("rollover", 0, 0, 0, 0, 4'b0000);

      // Random buttons against the model
      bi_r = 0;
      for (int i = 0; i < 3000; i++) begin
         bm_r = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0) bi_r = !bi_r;
         step(bm_r, bi_r);
      end

      // Asynchronous reset in the middle of an edit
      do_reset();
      set_time(12, 34, 1'b0);
      check_exp("pre_reset", 12, 34, 0, 2, 4'b0000);
      #2;
      rst_n = 1'b0;
      #1;
      check_exp("async_reset", 0, 0, 0, 0, 4'b0000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
      check_exp("after_reset", 0, 0, 2, 0, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
